// File: rtl/seg_scan_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_scan_pkg : shared constants and types for the segment scanner  |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
package seg_scan_pkg;

  localparam int         NUM_DIGITS = 6;
  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [5:0] AN_OFF     = 6'h3F;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  typedef logic [2:0] digit_t;

  // Active-low one-cold enable; indices 6/7 shift out and stay dark.
  function automatic logic [5:0] an_select(input digit_t d);
    an_select = AN_OFF & ~(6'b00_0001 << d);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_scan_timer : digit slot counter, digit index and BLANK/DRIVE   |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int DIGIT_CYCLES = 10,
  parameter int BLANK_CYCLES = 2
) (
  input  logic   clk,
  input  logic   reset,
  output digit_t digit,
  output logic   slot_start,
  output logic   frame_start,
  output logic   in_drive
);

  localparam int SLOT_W = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGIT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);

  generate
    if (DIGIT_CYCLES < 2 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_params
      $error("seg_scan_timer: need DIGIT_CYCLES >= 2 and BLANK_CYCLES < DIGIT_CYCLES");
    end
  endgenerate

  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  digit_t            digit_q, digit_d;
  scan_state_e       state_q, state_d;

  always_comb begin
    slot_cnt_d = slot_cnt_q + 1'b1;
    digit_d    = digit_q;
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      digit_d    = (digit_q >= digit_t'(NUM_DIGITS - 1)) ? digit_t'(0) : digit_q + 3'd1;
    end
    // State tracks the count being loaded, so state_q always matches slot_cnt_q.
    state_d = (slot_cnt_d < BLANK_END) ? BLANK : DRIVE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt_q <= '0;
      digit_q    <= '0;
      state_q    <= BLANK;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      digit_q    <= digit_d;
      state_q    <= state_d;
    end
  end

  assign digit       = digit_q;
  assign slot_start  = (slot_cnt_q == '0);
  assign frame_start = slot_start && (digit_q == '0);
  assign in_drive    = (state_q == DRIVE);

endmodule
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_scan_mux : 6-digit multiplexed 7-segment driver with frame     |
// |                snapshot and anti-ghost blanking.                   |
// |                Optional blink feature: SEG_SCAN_BLINK_EN           |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int REFRESH_HZ   = 200,
  parameter int BLANK_CYCLES = 500
`ifdef SEG_SCAN_BLINK_EN
  ,
  parameter int BLINK_HZ     = 2
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] led_a,
  input  logic [6:0] led_b,
  input  logic [6:0] led_c,
  input  logic [6:0] led_d,
  input  logic [6:0] led_e,
  input  logic [6:0] led_f,
  input  logic       disp_en,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [5:0] blink_mask,
`endif
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       frame_done
);

  localparam int DIGIT_CYCLES = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);

  digit_t digit;
  logic   slot_start, frame_start, in_drive, blink_hide;

  seg_scan_timer #(
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .digit       (digit),
    .slot_start  (slot_start),
    .frame_start (frame_start),
    .in_drive    (in_drive)
  );

`ifdef SEG_SCAN_BLINK_EN
  localparam int HALF_PERIOD = CLK_HZ / (2 * BLINK_HZ);
  localparam int PH_W        = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;

  generate
    if (HALF_PERIOD < 1) begin : g_bad_blink
      $error("seg_scan_mux: BLINK_HZ too high for CLK_HZ");
    end
  endgenerate

  logic [PH_W-1:0] phase_cnt_q, phase_cnt_d;
  logic            phase_q, phase_d;

  always_comb begin
    phase_cnt_d = phase_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (phase_cnt_q == PH_W'(HALF_PERIOD - 1)) begin
      phase_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      phase_cnt_q <= phase_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_hide = phase_q && (|(blink_mask & ~an_select(digit)));
`else
  assign blink_hide = 1'b0;
`endif

  logic [6:0] snap_q [NUM_DIGITS];
  logic [6:0] snap_d [NUM_DIGITS];
  logic [6:0] seg_q, seg_d, seg_pick;
  logic [5:0] an_q, an_d;
  logic       frame_done_q, frame_done_d;
  logic       seen_q, seen_d;
  logic       show;

  always_comb begin
    snap_d = snap_q;
    if (frame_start) begin
      snap_d[0] = led_a;
      snap_d[1] = led_b;
      snap_d[2] = led_c;
      snap_d[3] = led_d;
      snap_d[4] = led_e;
      snap_d[5] = led_f;
    end

    seg_pick = SEG_OFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit == digit_t'(i)) seg_pick = snap_q[i];
    end

    show = in_drive && disp_en && (digit < digit_t'(NUM_DIGITS)) && !blink_hide;
    an_d  = show ? an_select(digit) : AN_OFF;
    seg_d = show ? seg_pick : SEG_OFF;

    // The frame-start slot right after reset is not the end of a scanned frame.
    seen_d       = seen_q | ~slot_start;
    frame_done_d = frame_start && seen_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) snap_q[i] <= SEG_OFF;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
      seen_q       <= 1'b0;
    end else begin
      snap_q       <= snap_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
      seen_q       <= seen_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Downstream display stage for the time-of-day counter block.
- Consumes the six active-low 7-segment patterns (led_a..led_f) and drives one physical, time-multiplexed 6-digit common-anode display.
- Uses one shared seg bus plus six active-low digit enables.
- Latches a coherent frame snapshot, scans the digits with anti-ghost blanking, and supports a global display enable.

Parameters:
- CLK_HZ, 50_000_000: input clock frequency.
- REFRESH_HZ, 200: full-frame (6-digit) refresh rate.
- BLANK_CYCLES, 500: blanked cycles at the start of each digit slot.
- Derived DIGIT_CYCLES = CLK_HZ/(REFRESH_HZ*6).
- Elaboration error if DIGIT_CYCLES < 2 or BLANK_CYCLES >= DIGIT_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- led_a..led_f  in  7 each  segment patterns, bit6=a..bit0=g, active-low; led_a = seconds ones .. led_f = hours tens
- disp_en  in  1  1 = display on; 0 = all digits dark, scan keeps running
- seg  out  7  shared segment bus, active-low, same bit order as inputs
- an  out  6  digit enables, active-low; an[i] selects the digit fed by input i (a=0..f=5)
- frame_done  out  1  one-cycle pulse at the end of every frame

Behaviour:
- Reset (reset low, asynchronous) forces:
  - seg=7'h7F, an=6'h3F, frame_done=0
  - digit index=0, slot_cnt=0
  - all six snapshot registers=7'h7F
  - state=BLANK
- Counters:
  - slot_cnt runs 0..DIGIT_CYCLES-1 and then wraps to 0; at each wrap the digit index advances 0→1→…→5→0.
- States:
  - BLANK while slot_cnt < BLANK_CYCLES.
  - DRIVE while slot_cnt >= BLANK_CYCLES.
  - Transitions are purely count-driven; there are no other states.
- Snapshot:
  - On every edge where digit==0 and slot_cnt==0, all six inputs are captured together.
  - Input changes mid-frame are never displayed until the next frame.
- Outputs are registered, one-cycle latency from state/count:
  - BLANK: an=6'h3F, seg=7'h7F.
  - DRIVE with disp_en=1: an = all ones except bit[digit]=0; seg = snapshot[digit].
  - DRIVE with disp_en=0: an=6'h3F, seg=7'h7F.
  - disp_en is sampled every cycle, with no snapshot.
- Never more than one an bit low in any cycle. The digit changes only inside BLANK, so there is no ghosting.
- frame_done:
  - Asserted for exactly one cycle, the cycle after digit==5 and slot_cnt==DIGIT_CYCLES-1.
  - Coincides with the first BLANK output of digit 0.
- First frame after reset release:
  - The snapshot is taken on the first clock edge with reset high.
  - Digit 0 is driven from cycle BLANK_CYCLES+1 onward.
- Reset mid-frame: outputs go dark immediately (asynchronously); the scan restarts at digit 0 with a fresh snapshot.
- Counter widths: $clog2(DIGIT_CYCLES) for slot_cnt, 3 bits for the digit index. Digit values 6/7 are unreachable and decode to blank.

Optional Feature:
- Macro: SEG_SCAN_BLINK_EN.
- With the macro defined:
  - Adds parameter BLINK_HZ (default 2) and input port blink_mask[5:0].
  - An internal phase bit toggles every CLK_HZ/(2*BLINK_HZ) cycles; reset value 0 = visible.
  - While phase=1, digits whose mask bit is 1 are treated as BLANK during their DRIVE window (an stays high).
  - The time-set stage uses this to flash the field being edited.
- Without the macro: no port, no counter, behaviour exactly as above.

Decomposition:
- Package seg_scan_pkg holds:
  - SEG_OFF=7'h7F, AN_OFF=6'h3F, NUM_DIGITS=6
  - the scan state enum {BLANK, DRIVE}
  - the digit-index typedef
- One natural sub-module: seg_scan_timer. It owns slot_cnt and the digit index, and emits slot_start, frame_start and in_drive strobes.
- The top level owns the snapshot, output decode and optional blink.

Test Plan (all scenarios use CLK_HZ=1200, REFRESH_HZ=20 → DIGIT_CYCLES=10, BLANK_CYCLES=2):
- Reset then steady inputs: led_a=7'h01, led_b=7'h4F.
  - After release, an=6'h3F for cycles 1-2.
  - an=6'h3E with seg=7'h01 for cycles 3-10.
  - Then 2 blank cycles, then an=6'h3D with seg=7'h4F.
- Frame pulse: frame_done high exactly once every 60 cycles, never two consecutive cycles.
- Mid-frame update: change led_c at cycle 15.
  - Digit 2 shows the old value in frame 1 and the new value from frame 2 onward.
- disp_en=0 for cycles 30-45: an=6'h3F and seg=7'h7F over that window (one-cycle lag). The scan position is unaffected afterwards.
- Async reset asserted at cycle 27 (digit 2, DRIVE):
  - an=6'h3F within the same cycle, before any clock edge.
  - After release, digit 0 is driven first.
- SEG_SCAN_BLINK_EN with BLINK_HZ=2, blink_mask=6'b110000: digits 4 and 5 are dark for cycles 300-599, while digits 0-3 scan normally.
